al_commit_ctrl: RTL

Active-list commit controller. Owns the head pointer, tail pointer and occupancy count of the active list. Reads the per-entry ready bits from the active-list ready-bit RAM at the head and retires the contiguous ready prefix, up to COMMIT_WIDTH per cycle. Drives the RAM's commit-side write ports, both to clear retired entries and to run the power-on and flush clear sweep. Sits between dispatch, which allocates at the tail, and the ready-bit RAM, which exposes commit read ports and commit write ports.

---
 rtl/al_commit_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/al_commit_ctrl.sv
// Active-list commit controller: owns head/tail/count, retires the ready prefix
// at the head, and drives the ready-bit RAM clear ports for commits and sweeps.
module al_commit_ctrl #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned INDEX          = 4,
  parameter int unsigned COMMIT_WIDTH   = 4,
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned DCNT_W         = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DCNT_W-1:0]                    dispatchCnt_i,
  input  logic                                 flush_i,
  input  logic [COMMIT_WIDTH-1:0]              readyBit_i,
  output logic [COMMIT_WIDTH-1:0][INDEX-1:0]   headAddr_o,
  output logic [COMMIT_WIDTH-1:0]              commitVld_o,
  output logic [$clog2(COMMIT_WIDTH):0]        commitCnt_o,
  output logic [COMMIT_WIDTH-1:0]              clrWe_o,
  output logic [COMMIT_WIDTH-1:0][INDEX-1:0]   clrAddr_o,
  output logic [INDEX-1:0]                     tailAddr_o,
  output logic [INDEX:0]                       freeSlots_o,
  output logic                                 alFull_o,
  output logic                                 alEmpty_o,
  output logic                                 alReady_o
);

  localparam int unsigned CNT_W  = INDEX + 1;
  localparam int unsigned CCNT_W = $clog2(COMMIT_WIDTH) + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [INDEX-1:0] head;
  logic [INDEX-1:0] tail;
  logic [INDEX-1:0] sp;
  logic [CNT_W-1:0] count;

  logic             run;
  logic             all_rdy;
  logic             accept;
  logic [CNT_W-1:0] acc_cnt;
  logic             sp_last;

  assign run         = (state == RUN);
  assign tailAddr_o  = tail;
  assign freeSlots_o = CNT_W'(DEPTH) - count;
  assign alFull_o    = (count == CNT_W'(DEPTH));
  assign alEmpty_o   = (count == '0);
  assign alReady_o   = run;
  assign sp_last     = (CNT_W'(sp) + CNT_W'(COMMIT_WIDTH)) == CNT_W'(DEPTH);

  // Requests wider than the dispatch port are malformed and dropped like an over-request.
  assign accept  = run && !flush_i
                   && (dispatchCnt_i <= DCNT_W'(DISPATCH_WIDTH))
                   && (CNT_W'(dispatchCnt_i) <= freeSlots_o);
  assign acc_cnt = accept ? CNT_W'(dispatchCnt_i) : '0;

  // Retire the contiguous ready prefix among the valid entries at the head.
  always_comb begin
    all_rdy     = 1'b1;
    headAddr_o  = '0;
    commitVld_o = '0;
    commitCnt_o = '0;
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      all_rdy       = all_rdy & readyBit_i[i];
      headAddr_o[i] = head + INDEX'(i);
      if (run && !flush_i && all_rdy && (CNT_W'(i) < count)) begin
        commitVld_o[i] = 1'b1;
        commitCnt_o    = commitCnt_o + CCNT_W'(1);
      end
    end
  end

  // Clear ports: full-width sweep in INIT, retired entries in RUN.
  always_comb begin
    clrWe_o   = '0;
    clrAddr_o = '0;
    if (run) begin
      clrWe_o   = commitVld_o;
      clrAddr_o = headAddr_o;
    end else begin
      clrWe_o = reset ? '0 : '1;
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
        clrAddr_o[i] = sp + INDEX'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      sp    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      state <= INIT;
      sp    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (state == INIT) begin
      sp <= sp + INDEX'(COMMIT_WIDTH);
      if (sp_last) begin
        state <= RUN;
      end
    end else begin
      head  <= head + INDEX'(commitCnt_o);
      tail  <= tail + INDEX'(acc_cnt);
      count <= count + acc_cnt - CNT_W'(commitCnt_o);
    end
  end

endmodule
